// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-PC register with a branch redirect mux, one pending
// redirect slot for branches that arrive while fetch is held, and an
// IF/ID flush strobe that is stretched over FLUSH_CYCLES cycles.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HOLD,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS_4,
  output logic [31:0] REDIRECT_PC,
  output logic        MUX_SELECT,
  output logic        FLUSH,
  output logic        PENDING
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HELD     = 2'd1,
    FLUSHING = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_q, pend_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        flush_q, flush_d;

  logic        apply;
  logic        capture;
  logic [31:0] redirect_raw;

  // Next-PC mux inputs and select; a queued redirect beats a fresh request
  // because the fresh one comes from a path the queued one will squash.
  always_comb begin
    redirect_raw = pend_q ? pend_tgt_q : BRANCH_TARGET;
    REDIRECT_PC  = {redirect_raw[31:2], 2'b00};
    PC_PLUS_4    = pc_q + 32'd4;
    apply        = !HOLD && (pend_q || BRANCH_TAKEN);
    // Only one slot: a redirect seen while already HELD is dropped.
    capture      = HOLD && BRANCH_TAKEN && (state_q != HELD);
    MUX_SELECT   = apply;
  end

  // Next-state computation for PC, pending slot, flush counter and FSM.
  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    flush_cnt_d = flush_cnt_q;
    flush_d     = 1'b0;
    state_d     = RUN;

    if (!HOLD) begin
      pc_d = apply ? REDIRECT_PC : PC_PLUS_4;
    end

    if (apply) begin
      pend_d = 1'b0;
    end else if (capture) begin
      pend_d     = 1'b1;
      pend_tgt_d = {BRANCH_TARGET[31:2], 2'b00};
    end

    // Counter runs down even while held; a new apply restarts it so the
    // strobe is stretched, never gapped.
    if (apply) begin
      flush_cnt_d = FLUSH_LOAD;
    end else if (flush_cnt_q != 3'd0) begin
      flush_cnt_d = flush_cnt_q - 3'd1;
    end

    flush_d = (flush_cnt_d != 3'd0);

    if (pend_d) begin
      state_d = HELD;
    end else if (flush_d) begin
      state_d = FLUSHING;
    end else begin
      state_d = RUN;
    end
  end

  // All state registers; reset overrides HOLD and any redirect in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_tgt_q  <= 32'd0;
      flush_cnt_q <= 3'd0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      flush_cnt_q <= flush_cnt_d;
      flush_q     <= flush_d;
    end
  end

  assign PC      = pc_q;
  assign FLUSH   = flush_q;
  assign PENDING = pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed cycle vectors push their hand-computed
// expected outputs into a queue; a negedge monitor pops and compares.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, HOLD, BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] PC, PC_PLUS_4, REDIRECT_PC;
  logic        MUX_SELECT, FLUSH, PENDING;

  typedef struct {
    int          row;
    logic [31:0] pc;
    logic        mux;
    logic        flush;
    logic        pend;
    logic [31:0] redir;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   row   = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET), .HOLD(HOLD), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .PC(PC), .PC_PLUS_4(PC_PLUS_4),
    .REDIRECT_PC(REDIRECT_PC), .MUX_SELECT(MUX_SELECT), .FLUSH(FLUSH),
    .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input int r, input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL row %0d %s: got %h want %h", r, nm, act, req);
    end
  endtask

  // Monitor: outputs are compared mid-cycle, away from the rising edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] pc4;
      e   = exp_q.pop_front();
      pc4 = e.pc + 32'd4;
      chk(e.row, "PC",          PC,                 e.pc);
      chk(e.row, "PC_PLUS_4",   PC_PLUS_4,          pc4);
      chk(e.row, "MUX_SELECT",  {31'd0, MUX_SELECT}, {31'd0, e.mux});
      chk(e.row, "FLUSH",       {31'd0, FLUSH},      {31'd0, e.flush});
      chk(e.row, "PENDING",     {31'd0, PENDING},    {31'd0, e.pend});
      chk(e.row, "REDIRECT_PC", REDIRECT_PC,        e.redir);
    end
  end

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input logic rst, input logic hold, input logic bt,
                      input logic [31:0] tgt, input logic [31:0] epc,
                      input logic emux, input logic efl, input logic epd,
                      input logic [31:0] ered);
    exp_t e;
    RESET = rst; HOLD = hold; BRANCH_TAKEN = bt; BRANCH_TARGET = tgt;
    row++;
    e.row = row; e.pc = epc; e.mux = emux; e.flush = efl; e.pend = epd;
    e.redir = ered;
    exp_q.push_back(e);
    @(posedge CLK); #1;
  endtask

  initial begin
    RESET = 1'b1; HOLD = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h1234;
    @(posedge CLK); @(posedge CLK); #1;
    //    rst hold bt  target        pc            mux fl pd redirect
    // sequential run
    step(0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0,        32'h4,        0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0,        32'h8,        0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0,        32'hC,        0, 0, 0, 32'h0);
    // branch at 0x10
    step(0, 0, 1, 32'h200,      32'h10,       1, 0, 0, 32'h200);
    step(0, 0, 0, 32'h0,        32'h200,      0, 1, 0, 32'h0);
    step(0, 0, 0, 32'h0,        32'h204,      0, 1, 0, 32'h0);
    step(0, 0, 0, 32'h0,        32'h208,      0, 0, 0, 32'h0);
    // redirect during a 3-cycle hold; second request ignored
    step(0, 1, 0, 32'h0,        32'h20C,      0, 0, 0, 32'h0);
    step(0, 1, 1, 32'h80,       32'h20C,      0, 0, 0, 32'h80);
    step(0, 1, 1, 32'h90,       32'h20C,      0, 0, 1, 32'h80);
    step(0, 0, 0, 32'h0,        32'h20C,      1, 0, 1, 32'h80);
    step(0, 0, 0, 32'h0,        32'h80,       0, 1, 0, 32'h0);
    step(0, 0, 0, 32'h0,        32'h84,       0, 1, 0, 32'h0);
    step(0, 0, 0, 32'h0,        32'h88,       0, 0, 0, 32'h0);
    // flush reload: second redirect one cycle into FLUSHING
    step(0, 0, 1, 32'h300,      32'h8C,       1, 0, 0, 32'h300);
    step(0, 0, 1, 32'h40,       32'h300,      1, 1, 0, 32'h40);
    step(0, 0, 0, 32'h0,        32'h40,       0, 1, 0, 32'h0);
    step(0, 0, 0, 32'h0,        32'h44,       0, 1, 0, 32'h0);
    step(0, 0, 0, 32'h0,        32'h48,       0, 0, 0, 32'h0);
    // alignment, then wrap from 0xFFFF_FFFC
    step(0, 0, 1, 32'h103,      32'h4C,       1, 0, 0, 32'h100);
    step(0, 0, 1, 32'hFFFF_FFFF, 32'h100,     1, 1, 0, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0,        32'hFFFF_FFFC, 0, 1, 0, 32'h0);
    step(0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 32'h0);
    step(0, 0, 0, 32'h0,        32'h4,        0, 0, 0, 32'h0);
    // reset with PENDING=1 and FLUSH=1
    step(0, 0, 1, 32'h500,      32'h8,        1, 0, 0, 32'h500);
    step(0, 1, 1, 32'h600,      32'h500,      0, 1, 0, 32'h600);
    step(1, 1, 0, 32'h0,        32'h500,      0, 1, 1, 32'h600);
    step(0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0,        32'h4,        0, 0, 0, 32'h0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset (bits [1:0] zero).
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, range 1-7, giving the number of cycles FLUSH is asserted per redirect.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit, a synchronous active-high reset sampled on the rising edge of CLK.
REQ-005 The block SHALL have port HOLD, input, 1 bit, a fetch hold (instruction memory busy or hazard stall) that freezes the PC.
REQ-006 The block SHALL have port BRANCH_TAKEN, input, 1 bit, a redirect request from EX, valid for one cycle.
REQ-007 The block SHALL have port BRANCH_TARGET, input, 32 bits, the redirect address, valid when BRANCH_TAKEN=1.
REQ-008 The block SHALL have port PC, output, 32 bits, the registered current fetch address.
REQ-009 The block SHALL have port PC_PLUS_4, output, 32 bits, combinational PC+4 (mux input 0).
REQ-010 The block SHALL have port REDIRECT_PC, output, 32 bits, the combinational redirect address (mux input 1).
REQ-011 The block SHALL have port MUX_SELECT, output, 1 bit, the combinational select for the 32-bit 2:1 next-PC mux (0=PC_PLUS_4, 1=REDIRECT_PC).
REQ-012 The block SHALL have port FLUSH, output, 1 bit, a registered IF/ID squash strobe.
REQ-013 The block SHALL have port PENDING, output, 1 bit, registered, high while a redirect captured during HOLD awaits application.

Function
REQ-014 The states SHALL be RUN, HELD and FLUSHING, plus a 32-bit pending-target register and a 3-bit flush counter.
REQ-015 The "apply" condition SHALL be HOLD=0 and (PENDING=1 or BRANCH_TAKEN=1); when it holds, MUX_SELECT SHALL be 1 and PC SHALL load REDIRECT_PC on the next edge.
REQ-016 REDIRECT_PC SHALL be the pending target when PENDING=1, else BRANCH_TARGET, with bits [1:0] forced to 2'b00 in both cases.
REQ-017 When HOLD=0 and there is no apply condition, MUX_SELECT SHALL be 0 and PC SHALL load PC+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-018 When HOLD=1, PC SHALL hold its value and MUX_SELECT SHALL be 0.
REQ-019 On BRANCH_TAKEN=1 with HOLD=1 and PENDING=0, the block SHALL capture the target, set PENDING=1 on the next edge and enter HELD.
REQ-020 On BRANCH_TAKEN=1 with PENDING=1, the block SHALL ignore the new request; the first redirect wins because the later one belongs to a squashed path.
REQ-021 An apply SHALL clear PENDING on the same edge that PC loads the target.
REQ-022 On an apply, the flush counter SHALL load FLUSH_CYCLES and FLUSH SHALL be 1 for exactly FLUSH_CYCLES cycles, starting the cycle after the edge.
REQ-023 The flush counter SHALL decrement every cycle regardless of HOLD; the block SHALL enter FLUSHING when the counter is nonzero and RUN when it reaches 0.
REQ-024 A new apply during FLUSHING SHALL reload the counter to FLUSH_CYCLES, so FLUSH is extended rather than OR'd.
REQ-025 A redirect accepted from a HOLD cycle SHALL be applied on the first cycle with HOLD=0, with no cycle lost.

Reset
REQ-026 When RESET=1 at an edge, the block SHALL set PC=RESET_PC, state=RUN, FLUSH=0, PENDING=0, pending target=0 and counter=0, overriding HOLD and BRANCH_TAKEN in that cycle.
REQ-027 A reset in mid-flush or mid-pending SHALL discard the redirect.
REQ-028 The first cycle after reset SHALL fetch at RESET_PC.

Verification
REQ-029 Sequential run test: reset, then 4 idle cycles -> PC 0,4,8,C,10; MUX_SELECT=0; FLUSH=0.
REQ-030 Branch test: at PC=0x10, BRANCH_TAKEN=1 and BRANCH_TARGET=0x200 -> MUX_SELECT=1 that cycle; next PC=0x200, then 0x204; FLUSH=1 for exactly 2 cycles.
REQ-031 Redirect during hold: HOLD=1 for 3 cycles, BRANCH_TAKEN pulse to 0x80 in cycle 1 and a second pulse to 0x90 in cycle 2 -> PENDING=1; PC frozen; on HOLD release PC=0x80 and the 0x90 request is ignored.
REQ-032 Wrap and alignment test: PC=0xFFFF_FFFC, idle -> PC=0; a branch to 0x103 -> PC=0x100.
REQ-033 Flush reload test: a second redirect to 0x40 one cycle into FLUSHING -> FLUSH stays high for 1+2 cycles contiguous; PC=0x40.
REQ-034 Reset mid-operation: RESET asserted with PENDING=1 and FLUSH=1 -> next cycle PC=RESET_PC, PENDING=0, FLUSH=0.
